// File: rtl/led_ctrl_pkg.sv
// led_ctrl_pkg: register offsets and reset values shared by the LED controller.
`default_nettype none

package led_ctrl_pkg;

    localparam logic [15:0] OFF_ON     = 16'd0;
    localparam logic [15:0] OFF_BLINK  = 16'd1;
    localparam logic [15:0] OFF_PERIOD = 16'd2;
    localparam logic [15:0] OFF_DUTY0  = 16'd3;

    localparam logic [7:0]  PERIOD_RST = 8'd15;

endpackage

`default_nettype wire

// File: rtl/led_pwm_channel.sv
// led_pwm_channel: per-channel PWM compare and on/blink/pwm gating.
`default_nettype none

module led_pwm_channel
    import led_ctrl_pkg::*;
#(
    parameter int PWM_BITS = 8
) (
    input  logic                on_en_i,
    input  logic                blink_en_i,
    input  logic                blink_phase_i,
    input  logic [PWM_BITS-1:0] duty_i,
    input  logic [PWM_BITS-1:0] cnt_i,
    output logic                on_o
);

    logic w_pwm_on;

    // All-ones duty is solid on, so full brightness has no one-cycle gap per period.
    always_comb begin
        w_pwm_on = 1'b0;
        if (&duty_i) begin
            w_pwm_on = 1'b1;
        end else if (duty_i == '0) begin
            w_pwm_on = 1'b0;
        end else begin
            w_pwm_on = (cnt_i < duty_i);
        end
        on_o = on_en_i & (blink_en_i ? blink_phase_i : 1'b1) & w_pwm_on;
    end

endmodule

`default_nettype wire

// File: rtl/led_ctrl.sv
// led_ctrl: MMIO-programmed LED driver with per-channel PWM dimming and shared blink.
`default_nettype none

module led_ctrl
    import led_ctrl_pkg::*;
#(
    parameter int          NUM_LEDS   = 6,
    parameter int          PWM_BITS   = 8,
    parameter logic [15:0] BASE_ADDR  = 16'hF000,
    parameter bit          ACTIVE_LOW = 1'b1,
    parameter int          BLINK_TICK = 16
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                mmio_we,
    input  logic                mmio_re,
    input  logic [15:0]         mmio_addr,
    input  logic [7:0]          mmio_wdata,
    output logic [7:0]          mmio_rdata,
    output logic                mmio_rvalid,
    output logic [NUM_LEDS-1:0] led
);

    logic [NUM_LEDS-1:0]   on_q, on_d, blink_q, blink_d, led_q, led_d;
    logic [7:0]            period_q, period_d, blink_cnt_q, blink_cnt_d, rdata_q, rdata_d;
    logic [PWM_BITS-1:0]   duty_q [NUM_LEDS];
    logic [PWM_BITS-1:0]   duty_d [NUM_LEDS];
    logic [PWM_BITS-1:0]   pwm_cnt_q, pwm_cnt_d;
    logic [BLINK_TICK-1:0] presc_q, presc_d;
    logic                  phase_q, phase_d, rvalid_q, rvalid_d;

    logic [15:0]           w_off;
    logic                  w_tick;
    logic [7:0]            w_rd_val;
    logic [NUM_LEDS-1:0]   w_chan_on;
    logic                  w_unused;

    // Out-of-window addresses wrap to large offsets and decode as unmapped.
    assign w_off    = mmio_addr - BASE_ADDR;
    assign w_tick   = &presc_q;
    assign w_unused = ^mmio_wdata;

    always_comb begin
        on_d        = on_q;
        blink_d     = blink_q;
        period_d    = period_q;
        duty_d      = duty_q;
        pwm_cnt_d   = pwm_cnt_q + PWM_BITS'(1);
        presc_d     = presc_q + BLINK_TICK'(1);
        blink_cnt_d = blink_cnt_q;
        phase_d     = phase_q;

        if (w_tick) begin
            if (blink_cnt_q == period_q) begin
                blink_cnt_d = 8'd0;
                phase_d     = ~phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 8'd1;
            end
        end

        if (mmio_we) begin
            if (w_off == OFF_ON)    on_d    = mmio_wdata[NUM_LEDS-1:0];
            if (w_off == OFF_BLINK) blink_d = mmio_wdata[NUM_LEDS-1:0];
            // A period write restarts the blink so the new rate begins with the LED lit.
            if (w_off == OFF_PERIOD) begin
                period_d    = mmio_wdata;
                presc_d     = '0;
                blink_cnt_d = 8'd0;
                phase_d     = 1'b1;
            end
            for (int i = 0; i < NUM_LEDS; i++) begin
                if (w_off == OFF_DUTY0 + 16'(i)) duty_d[i] = mmio_wdata[PWM_BITS-1:0];
            end
        end

        led_d = w_chan_on ^ {NUM_LEDS{ACTIVE_LOW}};
    end

    // Read mux uses current register values, so read-during-write returns old data.
    always_comb begin
        w_rd_val = 8'h00;
        if (w_off == OFF_ON)     w_rd_val = 8'(on_q);
        if (w_off == OFF_BLINK)  w_rd_val = 8'(blink_q);
        if (w_off == OFF_PERIOD) w_rd_val = period_q;
        for (int i = 0; i < NUM_LEDS; i++) begin
            if (w_off == OFF_DUTY0 + 16'(i)) w_rd_val = 8'(duty_q[i]);
        end
        rvalid_d = mmio_re;
        rdata_d  = mmio_re ? w_rd_val : 8'h00;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            on_q        <= '0;
            blink_q     <= '0;
            period_q    <= PERIOD_RST;
            for (int i = 0; i < NUM_LEDS; i++) duty_q[i] <= '1;
            pwm_cnt_q   <= '0;
            presc_q     <= '0;
            blink_cnt_q <= 8'd0;
            phase_q     <= 1'b1;
            rvalid_q    <= 1'b0;
            rdata_q     <= 8'h00;
            led_q       <= {NUM_LEDS{ACTIVE_LOW}};
        end else begin
            on_q        <= on_d;
            blink_q     <= blink_d;
            period_q    <= period_d;
            duty_q      <= duty_d;
            pwm_cnt_q   <= pwm_cnt_d;
            presc_q     <= presc_d;
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
            rvalid_q    <= rvalid_d;
            rdata_q     <= rdata_d;
            led_q       <= led_d;
        end
    end

    for (genvar g = 0; g < NUM_LEDS; g++) begin : g_ch
        led_pwm_channel #(
            .PWM_BITS (PWM_BITS)
        ) u_ch (
            .on_en_i       (on_q[g]),
            .blink_en_i    (blink_q[g]),
            .blink_phase_i (phase_q),
            .duty_i        (duty_q[g]),
            .cnt_i         (pwm_cnt_q),
            .on_o          (w_chan_on[g])
        );
    end

    assign led         = led_q;
    assign mmio_rdata  = rdata_q;
    assign mmio_rvalid = rvalid_q;

endmodule

`default_nettype wire

// File: tb/tb_led_ctrl.sv
// tb_led_ctrl: directed, table-driven check of led_ctrl with 4-bit PWM and 4-cycle blink tick.
`default_nettype none

module tb_led_ctrl;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       mmio_we = 1'b0;
    logic       mmio_re = 1'b0;
    logic [15:0] mmio_addr = 16'h0000;
    logic [7:0]  mmio_wdata = 8'h00;
    logic [7:0]  mmio_rdata;
    logic        mmio_rvalid;
    logic [5:0]  led;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  exp;
    } reg_vec_t;

    typedef struct {
        logic [7:0] duty;
        int         exp_low;
    } duty_vec_t;

    reg_vec_t  rv [9];
    duty_vec_t dv [5];

    led_ctrl #(
        .NUM_LEDS   (6),
        .PWM_BITS   (4),
        .BASE_ADDR  (16'hF000),
        .ACTIVE_LOW (1'b1),
        .BLINK_TICK (2)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .mmio_we     (mmio_we),
        .mmio_re     (mmio_re),
        .mmio_addr   (mmio_addr),
        .mmio_wdata  (mmio_wdata),
        .mmio_rdata  (mmio_rdata),
        .mmio_rvalid (mmio_rvalid),
        .led         (led)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] d);
        @(negedge clock);
        mmio_we = 1'b1; mmio_addr = a; mmio_wdata = d;
        @(negedge clock);
        mmio_we = 1'b0;
    endtask

    task automatic rd(input logic [15:0] a, input logic [7:0] exp, input string nm);
        @(negedge clock);
        mmio_re = 1'b1; mmio_addr = a;
        @(negedge clock);
        mmio_re = 1'b0;
        chk({nm, "_rvalid"}, 32'(mmio_rvalid), 32'd1);
        chk({nm, "_rdata"}, 32'(mmio_rdata), 32'(exp));
    endtask

    initial begin
        int lows;

        rv[0] = '{16'hF000, 8'hFF, 8'h3F};
        rv[1] = '{16'hF001, 8'hC5, 8'h05};
        rv[2] = '{16'hF002, 8'h07, 8'h07};
        rv[3] = '{16'hF003, 8'hFF, 8'h0F};
        rv[4] = '{16'hF004, 8'hA9, 8'h09};
        rv[5] = '{16'hF008, 8'h33, 8'h03};
        rv[6] = '{16'hF009, 8'h55, 8'h00};
        rv[7] = '{16'hEFFF, 8'h12, 8'h00};
        rv[8] = '{16'hF0F0, 8'h77, 8'h00};

        dv[0] = '{8'd4,  4};
        dv[1] = '{8'd0,  0};
        dv[2] = '{8'd1,  1};
        dv[3] = '{8'd14, 14};
        dv[4] = '{8'd15, 16};

        // Reset state and ON write latency
        do_reset();
        chk("rst_led", 32'(led), 32'h3F);
        chk("rst_rvalid", 32'(mmio_rvalid), 32'd0);
        chk("rst_rdata", 32'(mmio_rdata), 32'd0);
        wr(16'hF000, 8'h3F);
        chk("on_lat1", 32'(led), 32'h3F);
        @(negedge clock);
        chk("on_lat2", 32'(led), 32'h00);

        // Register write/readback table
        for (int k = 0; k < 9; k++) begin
            wr(rv[k].addr, rv[k].wdata);
            rd(rv[k].addr, rv[k].exp, $sformatf("reg%0d", k));
        end
        @(negedge clock);
        chk("idle_rvalid", 32'(mmio_rvalid), 32'd0);
        chk("idle_rdata", 32'(mmio_rdata), 32'd0);
        rd(16'hF000, 8'h3F, "after_unmapped_on");
        rd(16'hF003, 8'h0F, "after_unmapped_duty0");

        // Read and write to the same address in one cycle
        @(negedge clock);
        mmio_we = 1'b1; mmio_re = 1'b1; mmio_addr = 16'hF000; mmio_wdata = 8'h2A;
        @(negedge clock);
        mmio_we = 1'b0; mmio_re = 1'b0;
        chk("rw_same_old", 32'(mmio_rdata), 32'h3F);
        rd(16'hF000, 8'h2A, "rw_same_new");

        // Duty sweep: count active-low cycles over one full PWM period
        do_reset();
        wr(16'hF000, 8'h01);
        for (int k = 0; k < 5; k++) begin
            wr(16'hF003, dv[k].duty);
            repeat (2) @(negedge clock);
            lows = 0;
            for (int c = 0; c < 16; c++) begin
                if (led[0] == 1'b0) lows++;
                @(negedge clock);
            end
            chk($sformatf("duty%0d_lows", dv[k].duty), 32'(lows), 32'(dv[k].exp_low));
        end

        // Blink: P=1 gives 8-cycle half periods, restarted by the period write
        do_reset();
        wr(16'hF001, 8'h01);
        wr(16'hF000, 8'h01);
        wr(16'hF002, 8'h01);
        for (int m = 1; m <= 28; m++) begin
            @(negedge clock);
            chk($sformatf("blink_m%0d", m), 32'(led[0]), 32'(((m - 1) / 8) % 2));
        end
        wr(16'hF002, 8'h01);
        chk("restart_m0", 32'(led[0]), 32'd1);
        @(negedge clock);
        chk("restart_m1", 32'(led), 32'h3E);
        repeat (7) @(negedge clock);
        chk("restart_m8", 32'(led[0]), 32'd0);
        @(negedge clock);
        chk("restart_m9", 32'(led[0]), 32'd1);

        // Reset arriving while a read is being issued mid-blink
        wr(16'hF003, 8'h05);
        repeat (5) @(negedge clock);
        mmio_re = 1'b1; mmio_addr = 16'hF003;
        #2 reset = 1'b1;
        #1;
        chk("midrst_rvalid", 32'(mmio_rvalid), 32'd0);
        chk("midrst_rdata", 32'(mmio_rdata), 32'd0);
        chk("midrst_led", 32'(led), 32'h3F);
        @(negedge clock);
        mmio_re = 1'b0;
        chk("midrst_rvalid2", 32'(mmio_rvalid), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        rd(16'hF000, 8'h00, "post_rst_on");
        rd(16'hF001, 8'h00, "post_rst_blink");
        rd(16'hF002, 8'h0F, "post_rst_period");
        rd(16'hF003, 8'h0F, "post_rst_duty0");
        rd(16'hF008, 8'h0F, "post_rst_duty5");
        chk("post_rst_led", 32'(led), 32'h3F);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/led_ctrl.md
LED_CTRL -- requirements
Module: led_ctrl

Interface
REQ-001 Parameters, one per line (name, default, meaning):
- NUM_LEDS, 6, channel count; legal range 1..8.
- PWM_BITS, 8, PWM counter and duty width; legal range 2..8.
- BASE_ADDR, 16'hF000, MMIO base address.
- ACTIVE_LOW, 1, 1 = led pins are driven inverted.
- BLINK_TICK, 16, log2 of clock cycles per blink tick.

REQ-002 Ports, one per line (name, direction, width, meaning):
- clock  in  1  system clock.
- reset  in  1  reset; asynchronous, active-high.
- mmio_we  in  1  write strobe.
- mmio_re  in  1  read strobe.
- mmio_addr  in  16  byte address.
- mmio_wdata  in  8  write data.
- mmio_rdata  out  8  read data.
- mmio_rvalid  out  1  read-data valid pulse.
- led  out  NUM_LEDS  pin drive.

REQ-003 The block SHALL have reset reset, asynchronous, active-high; clock clock.

Function
REQ-004 Register map, as offsets from BASE_ADDR:
- +0 ON mask.
- +1 BLINK enable mask.
- +2 BLINK period P (8 bit).
- +3+i DUTY[i] for i < NUM_LEDS.

REQ-005 A write SHALL take effect when mmio_we=1 and mmio_addr matches a mapped register; it updates that register at the rising edge.

REQ-006 Unmapped writes SHALL be ignored; write bits at or above NUM_LEDS in a mask, or at or above PWM_BITS in a duty, SHALL be discarded.

REQ-007 mmio_re=1 SHALL produce mmio_rvalid=1 for exactly one cycle, on the next cycle, with mmio_rdata holding the register value zero-extended.
- Unmapped reads SHALL return 8'h00.
- mmio_rdata SHALL be 8'h00 whenever mmio_rvalid=0.

REQ-008 Simultaneous read and write to the same address SHALL return the pre-write value.

REQ-009 A free-running PWM counter of PWM_BITS width SHALL increment every cycle and wrap from all-ones to 0.

REQ-010 pwm_on[i] SHALL be:
- 1 when DUTY[i] is all-ones;
- 0 when DUTY[i] = 0;
- otherwise (counter < DUTY[i]).

REQ-011 A prescaler SHALL emit a one-cycle tick every 2^BLINK_TICK cycles.

REQ-012 On each tick, the blink counter SHALL compare to P:
- if equal, it clears to 0 and blink_phase toggles;
- otherwise it increments.
- The phase period is (P+1) ticks per half-cycle.

REQ-013 Any write to +2 SHALL clear the prescaler and the blink counter and set blink_phase=1 in the same edge.

REQ-014 Channel state on[i] SHALL equal ON[i] AND (BLINK[i] ? blink_phase : 1) AND pwm_on[i].

REQ-015 led SHALL be registered: led[i] = on[i] XOR ACTIVE_LOW, one cycle after the state that produced it. Register-write-to-pin latency is therefore 2 cycles when pwm_on=1.

REQ-016 Writes to DUTY SHALL take effect immediately; no period-boundary synchronisation.

Reset
REQ-017 On reset assertion, all of the following SHALL hold asynchronously:
- ON=0, BLINK=0, P=8'd15, DUTY[i]=all-ones;
- PWM counter, prescaler and blink counter = 0; blink_phase=1;
- mmio_rvalid=0, mmio_rdata=0;
- led = all-ones when ACTIVE_LOW=1, else all-zeros.

REQ-018 Reset asserted mid-read SHALL suppress the pending mmio_rvalid.

Structure
REQ-019 Package led_ctrl_pkg SHALL hold the register offset constants (OFF_ON=0, OFF_BLINK=1, OFF_PERIOD=2, OFF_DUTY0=3).

REQ-020 Sub-module led_pwm_channel SHALL implement REQ-010 and REQ-014 for one channel. It is instantiated NUM_LEDS times by generate; the counters and the register file stay in led_ctrl.

Verification
REQ-021 The bench SHALL run with BLINK_TICK=2 and PWM_BITS=4, and SHALL cover the following directed scenarios:
- Reset, then write ON=6'h3F to F000 -> led=6'h00 two cycles later.
- Duty: write DUTY[0]=4'd4 and ON=1 -> led[0] is low 4 of every 16 cycles, high 12; DUTY[0]=0 -> led[0] constant 1.
- Blink: write P=1 and BLINK=1 with ON=1 -> led[0] toggles every 8 cycles; a period write mid-cycle restarts the phase with led[0] low (on) two cycles later.
- Read: write F003=8'hFF, then read -> rdata=8'h0F with rvalid one cycle later.
- Unmapped: read F0F0 -> 8'h00 with rvalid; write F0F0 -> no register changes.
- Reset asserted mid-blink with pending read -> rvalid=0, led=6'h3F, all registers at reset values.
